multi_timer: RTL and testbench
==============================

// Module: multi_timer
// PURPOSE
//   Parametrised multi-channel countdown timer; next generation of the single-channel timer.
//   NUM_CH independent channels, each with its own enable, period and mode (one-shot or periodic).
//   Each channel emits a one-clock timeup pulse when its period expires.
//   Used by the melody sequencer for note durations, beat ticks and game-event delays.
// PARAMETERS
//   NUM_CH    2    number of independent channels (>=1)
//   WIDTH     32   period/counter width in bits
//   PRESCALE  1    clk cycles per timer tick; used only with TIMER_PRESCALE_EN (>=1)
// PORTS
//   clk       in   1             system clock, all logic on rising edge
//   rst       in   1             synchronous reset, active-high
//   en        in   NUM_CH        per-channel enable; low = abort/clear channel
//   period    in   NUM_CH*WIDTH  channel i period in ticks at [i*WIDTH +: WIDTH]
//   periodic  in   NUM_CH        1 = auto-reload, 0 = one-shot
//   timeup    out  NUM_CH        registered one-cycle expiry pulse per channel
//   busy      out  NUM_CH        1 while channel is counting (state RUN)
// BEHAVIOUR
//   - Reset: every channel to IDLE, cnt=0, timeup=0, busy=0, prescaler=0. rst overrides all inputs.
//   - Per-channel FSM, evaluated at each clk edge (channel i uses en[i], period[i], periodic[i]):
//     IDLE: en=1 and period!=0 -> capture period into P_reg, cnt<=0, go RUN. Otherwise stay.
//     RUN : en=0 -> IDLE, cnt<=0, no pulse.
//           tick and cnt==P_reg-1 -> timeup<=1. periodic=1: cnt<=0, recapture period.
//           periodic=0: go DONE. tick and cnt!=P_reg-1 -> cnt<=cnt+1.
//     DONE: hold, busy=0, no pulses. en=0 -> IDLE.
//   - Latency: timeup is high exactly P ticks after the edge that captured en. Without prescaler
//     this is P clk cycles, so P=1 gives a pulse on the next cycle.
//   - timeup is high for exactly one clk cycle per expiry and low in every other cycle.
//   - busy=1 only in RUN. busy stays 1 in the cycle timeup pulses on a periodic channel.
//     busy is 0 from that cycle on a one-shot channel.
//   - period is sampled only at capture (IDLE->RUN, or reload in periodic mode).
//     A change mid-period takes effect from the next period.
//   - period==0: the channel never leaves IDLE, never pulses, busy=0.
//   - Simultaneous en=0 and terminal count: abort wins, no pulse.
//   - To restart a running or finished channel, drop en for >=1 cycle.
//     Re-capture happens on the first edge with en=1 in IDLE.
//   - cnt is WIDTH bits and never exceeds P_reg-1, so no wrap-around is possible.
//   - rst mid-operation: all channels to IDLE on that edge. Channels with en=1 recapture
//     on the first edge after rst deasserts.
//   - Channels are fully independent; any combination may pulse in the same cycle.
// CONFIGURATION
//   TIMER_PRESCALE_EN defined:
//     - Shared free-running prescaler counts 0..PRESCALE-1.
//     - tick=1 only in the cycle where the prescaler equals PRESCALE-1.
//     - RUN counting advances only on tick; en=0 abort and capture still act on every clk edge.
//     - The first tick after capture is phase-dependent, so expiry takes (P-1)*PRESCALE+1
//       to P*PRESCALE cycles.
//   TIMER_PRESCALE_EN undefined:
//     - tick is constant 1 and no prescaler logic is built. PRESCALE is ignored.
// TESTING (NUM_CH=2, WIDTH=32; cycle numbers are clk edges after rst drops at edge 0)
//   1. Hold rst=1 with en=2'b11 and period=5 for 4 cycles -> timeup=0 and busy=0 throughout.
//   2. ch0 one-shot, period=2000, en[0]=1 captured at edge 10 -> single timeup[0] pulse
//      after edge 2010; busy[0] 1 over 11..2009; no further pulse through edge 6000.
//   3. ch1 periodic, period=5, captured at edge 0 -> pulses after edges 5, 10, 15.
//      Set period=3 at edge 12 -> next pulses after 15, 18, 21.
//   4. ch0 period=2000 captured at 10; en[0]=0 at edge 2110, back to 1 at edge 2120 ->
//      pulse after 2010; abort at 2110; recapture at 2120; next pulse after 4120.
//      Also: en[0]=0 exactly on the terminal edge -> no pulse.
//   5. Boundaries: period=0 with en=1 -> no pulse, busy=0.
//      Period=1 periodic -> timeup high every cycle from edge 1.
//      Assert rst at edge 7 of a period=10 run -> outputs 0 after 7; restart from rst release.
//   6. TIMER_PRESCALE_EN, PRESCALE=4, ch0 periodic, period=3, capture aligned so that
//      tick falls at edges 4, 8, 12 -> pulses every 12 cycles. Compile without the macro:
//      same stimulus -> pulses every 3 cycles.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel countdown timer with per-channel one-shot/periodic modes and a one-clock expiry pulse.
// Optional shared prescaler: define TIMER_PRESCALE_EN to advance counting once every PRESCALE clocks.
module multi_timer #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*WIDTH-1:0] period,
  input  logic [NUM_CH-1:0]       periodic,
  output logic [NUM_CH-1:0]       timeup,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state [NUM_CH];
  logic [WIDTH-1:0] cnt   [NUM_CH];
  logic [WIDTH-1:0] preg  [NUM_CH];
  logic             tick;

  if (NUM_CH < 1 || WIDTH < 1 || PRESCALE < 1) begin : g_bad_cfg
    $error("multi_timer: NUM_CH, WIDTH and PRESCALE must all be >= 1");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (psc == PSC_LAST) begin
      psc <= '0;
    end else begin
      psc <= psc + 1'b1;
    end
  end

  assign tick = (psc == PSC_LAST);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      timeup <= '0;
      busy   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        preg[i]  <= '0;
      end
    end else begin
      timeup <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (en[i] && (period[i*WIDTH +: WIDTH] != '0)) begin
              preg[i]  <= period[i*WIDTH +: WIDTH];
              cnt[i]   <= '0;
              state[i] <= RUN;
              busy[i]  <= 1'b1;
            end
          end
          RUN: begin
            if (!en[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
              busy[i]  <= 1'b0;
            end else if (tick) begin
              if (cnt[i] == preg[i] - 1'b1) begin
                timeup[i] <= 1'b1;
                cnt[i]    <= '0;
                if (periodic[i]) begin
                  // A zero period on reload parks the channel rather than counting a bogus length.
                  if (period[i*WIDTH +: WIDTH] != '0) begin
                    preg[i] <= period[i*WIDTH +: WIDTH];
                  end else begin
                    state[i] <= IDLE;
                    busy[i]  <= 1'b0;
                  end
                end else begin
                  state[i] <= DONE;
                  busy[i]  <= 1'b0;
                end
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
          end
          DONE: begin
            if (!en[i]) begin
              state[i] <= IDLE;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
            busy[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NUM_CH=2, WIDTH=32); expiry spacing check adapts to TIMER_PRESCALE_EN.
module tb_multi_timer;

  localparam int W = 32;
`ifdef TIMER_PRESCALE_EN
  localparam int EXP_SPACE = 12;
`else
  localparam int EXP_SPACE = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   en;
  logic [2*W-1:0] period;
  logic [1:0]   periodic;
  logic [1:0]   timeup;
  logic [1:0]   busy;

  int total  = 0;
  int passed = 0;

  multi_timer #(.NUM_CH(2), .WIDTH(W), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .period   (period),
    .periodic (periodic),
    .timeup   (timeup),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, output int p0, output int p1,
                           output int b0lo, output int b1lo);
    p0 = 0; p1 = 0; b0lo = 0; b1lo = 0;
    for (int k = 0; k < n; k++) begin
      step();
      p0   += timeup[0] ? 1 : 0;
      p1   += timeup[1] ? 1 : 0;
      b0lo += busy[0] ? 0 : 1;
      b1lo += busy[1] ? 0 : 1;
    end
  endtask

  initial begin
    int p0, p1, b0lo, b1lo;
    int first, gap;
    logic exp;

    // Reset dominates enabled, nonzero-period inputs
    rst = 1'b1; en = 2'b11; period = {32'd5, 32'd5}; periodic = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_timeup", timeup, 2'b00);
      check("rst_busy", busy, 2'b00);
    end

`ifndef TIMER_PRESCALE_EN
    // ch1 periodic period 5, switched to 3 mid-period
    en = 2'b10; periodic = 2'b10; period[63:32] = 32'd5;
    rst = 1'b0;
    step();
    check("ch1_busy_after_capture", busy[1], 1'b1);
    for (int k = 1; k <= 21; k++) begin
      if (k == 13) period[63:32] = 32'd3;
      step();
      exp = (k == 5 || k == 10 || k == 15 || k == 18 || k == 21);
      check($sformatf("ch1_periodic_k%0d", k), timeup[1], exp);
    end
    en[1] = 1'b0;
    step();
    check("ch1_abort_timeup", timeup[1], 1'b0);
    check("ch1_abort_busy", busy[1], 1'b0);

    // ch0 one-shot period 2000
    period[31:0] = 32'd2000; periodic[0] = 1'b0; en[0] = 1'b1;
    step();
    check("ch0_busy_capture", busy[0], 1'b1);
    run_count(1999, p0, p1, b0lo, b1lo);
    check("ch0_no_early_pulse", p0, 0);
    check("ch0_busy_held", b0lo, 0);
    step();
    check("ch0_expiry", timeup[0], 1'b1);
    check("ch0_busy_drop", busy[0], 1'b0);
    run_count(99, p0, p1, b0lo, b1lo);
    check("ch0_done_no_pulse", p0, 0);
    check("ch0_done_busy_low", b0lo, 99);
    en[0] = 1'b0;
    run_count(10, p0, p1, b0lo, b1lo);
    check("ch0_disabled_no_pulse", p0, 0);
    en[0] = 1'b1;
    step();
    check("ch0_recapture_busy", busy[0], 1'b1);
    run_count(1999, p0, p1, b0lo, b1lo);
    check("ch0_re_no_early", p0, 0);
    step();
    check("ch0_re_expiry", timeup[0], 1'b1);

    // en dropped exactly on the terminal edge: abort wins
    en[0] = 1'b0;
    step();
    period[31:0] = 32'd4; en[0] = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    en[0] = 1'b0;
    step();
    check("abort_terminal_timeup", timeup[0], 1'b0);
    check("abort_terminal_busy", busy[0], 1'b0);
    run_count(5, p0, p1, b0lo, b1lo);
    check("abort_terminal_later", p0, 0);

    // period 0 never starts
    period[31:0] = 32'd0; en[0] = 1'b1;
    run_count(5, p0, p1, b0lo, b1lo);
    check("p0_no_pulse", p0, 0);
    check("p0_busy_low", b0lo, 5);
    en[0] = 1'b0;

    // period 1 periodic pulses every cycle
    period[63:32] = 32'd1; periodic[1] = 1'b1; en[1] = 1'b1;
    step();
    check("p1_capture_no_pulse", timeup[1], 1'b0);
    run_count(6, p0, p1, b0lo, b1lo);
    check("p1_every_cycle", p1, 6);
    check("p1_busy_held", b1lo, 0);
    en[1] = 1'b0;
    step();

    // reset in the middle of a period-10 run
    period[31:0] = 32'd10; periodic[0] = 1'b0; en[0] = 1'b1;
    step();
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1;
    step();
    check("midrst_timeup", timeup, 2'b00);
    check("midrst_busy", busy, 2'b00);
    rst = 1'b0;
    step();
    check("postrst_busy", busy[0], 1'b1);
    run_count(9, p0, p1, b0lo, b1lo);
    check("postrst_no_early", p0, 0);
    step();
    check("postrst_expiry", timeup[0], 1'b1);

    // both channels expiring on the same edge
    en = 2'b00;
    step();
    period = {32'd3, 32'd3}; periodic = 2'b11; en = 2'b11;
    step();
    step(); step(); step();
    check("both_pulse", timeup, 2'b11);
    en = 2'b00;
    step();
`else
    rst = 1'b0;
    en = 2'b00;
    step();
`endif

    // ch0 periodic period 3: spacing between consecutive pulses
    period[31:0] = 32'd3; periodic = 2'b01; en = 2'b01;
    first = -1;
    for (int k = 0; k < 100 && first < 0; k++) begin
      step();
      if (timeup[0]) first = k;
    end
    check("spacing_first_seen", (first >= 0), 1'b1);
    gap = -1;
    for (int k = 1; k <= 100 && gap < 0; k++) begin
      step();
      if (timeup[0]) gap = k;
    end
    check("spacing_gap", gap, EXP_SPACE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
